spi_cs_arbiter: RTL and testbench
=================================

# spi_cs_arbiter

Round-robin arbiter that shares the single `spi_master` byte engine between `NUM_REQ` requesters, each of which owns one slave (requester i ↔ chip select i). It grants the engine, drives a one-hot chip-select vector, and sequences multi-byte transactions: one `eng_start` per byte, chip select held asserted until the requester marks the last byte. It sits between the system-side clients and `spi_master`.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters and chip selects (2..8)
- `BYTE_LEN`, 8, byte width
- `CS_GAP`, 2, idle cycles with all chip selects deasserted between transactions (≥1)
- `HOLD_MAX`, 64, consecutive starved cycles allowed mid-transaction before forced release (≥1)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  NUM_REQ  requester i has a byte to send
- `req_last`  in  NUM_REQ  byte offered by requester i is the final byte of its transaction
- `req_data`  in  NUM_REQ*BYTE_LEN  bytes to send; slice i belongs to requester i
- `req_ready`  out  NUM_REQ  byte accepted from requester i this cycle
- `rsp_valid`  out  NUM_REQ  one-cycle pulse: `rsp_data` holds requester i's received byte
- `rsp_data`  out  BYTE_LEN  received byte, shared by all requesters
- `hold_timeout`  out  1  one-cycle pulse on a forced release
- `eng_start`  out  1  one-cycle pulse: engine sends `eng_tx_data`
- `eng_tx_data`  out  BYTE_LEN  byte to serialize
- `eng_cs_sel`  out  NUM_REQ  one-hot active-high slave select; engine drives `cs_n = ~eng_cs_sel`
- `eng_busy`  in  1  engine is shifting
- `eng_done`  in  1  one-cycle pulse: byte complete, `eng_rx_data` valid
- `eng_rx_data`  in  BYTE_LEN  byte received from the slave

## Operation
- States: IDLE, SEND, WAIT, GAP.
- Registers: `grant` index, `ptr` round-robin pointer, `last_q`, starve counter, gap counter.
- IDLE: if any `req_valid`, select the first set bit searching from `ptr` upward with wrap. Register it as `grant`, set `eng_cs_sel = 1<<grant`, go to SEND. No request: stay.
- SEND: `req_ready[grant] = req_valid[grant] && !eng_busy`. This is combinational and the only source of `req_ready`. On accept, register `eng_start=1`, `eng_tx_data=req_data[grant]`, `last_q=req_last[grant]`, then go to WAIT.
- SEND starvation: while `req_valid[grant]=0`, increment the starve counter; reset it on any accept. When it reaches `HOLD_MAX`, pulse `hold_timeout` and go to GAP.
- WAIT: on `eng_done`, register `rsp_data=eng_rx_data` and pulse `rsp_valid[grant]` for one cycle. If `last_q`, go to GAP; otherwise go to SEND.
- GAP: `eng_cs_sel=0`; set `ptr=(grant+1) mod NUM_REQ`. Hold for `CS_GAP` cycles, then go to IDLE.
- Requests from non-granted requesters are ignored; their `req_ready` stays 0.
- `eng_done` outside WAIT is ignored.
- `eng_cs_sel` is never multi-hot and never changes while in SEND or WAIT.

## Timing
- Reset (async assert, sync release): state IDLE, `ptr=0`. All outputs 0: `req_ready`, `rsp_valid`, `rsp_data`, `hold_timeout`, `eng_start`, `eng_tx_data`, `eng_cs_sel`.
- Latency from idle: `req_valid` high at edge N → `eng_cs_sel` set after N. `req_ready` is high during cycle N+1 → `eng_start` high during cycle N+2.
- `eng_start` is exactly one cycle wide and is never asserted while `eng_busy=1`.
- `eng_done` at edge M → `rsp_valid`/`rsp_data` visible during cycle M+1. The next byte's `req_ready` can be high in that same cycle M+1.
- Last byte: chip select deasserts the cycle after `rsp_valid`, stays deasserted for `CS_GAP` cycles, and the earliest next grant follows.
- Simultaneous requests: the lowest index at or above `ptr` wins. A requester continuously requesting is re-granted only after every other pending requester has been served once.
- Reset mid-transaction: chip select drops immediately and the in-flight byte is abandoned. No `rsp_valid` is issued.

## Test plan
- Single byte: req 2 with `req_last=1`, data 0xA5, engine returns 0x3C → `eng_cs_sel=4'b0100`, one `eng_start` with 0xA5, `rsp_valid[2]` with 0x3C, then `CS_GAP` cycles of `eng_cs_sel=0`.
- Burst: req 1 sends 0x01, 0x02, 0x03 (last on 0x03) → three `eng_start` pulses, `eng_cs_sel=4'b0010` held continuously, three `rsp_valid[1]` pulses.
- Fairness: all four requesters request continuously, single bytes, from reset → grant order 0, 1, 2, 3, 0, 1. Never two transactions back-to-back to the same requester while another is pending.
- Starvation: req 3 sends one non-last byte, then drops `req_valid` → `hold_timeout` after exactly `HOLD_MAX` (64) cycles, chip select released, `ptr=0`.
- Async reset: assert `rst_n=0` mid-WAIT → `eng_cs_sel=0` and all outputs 0 immediately. After release, a new request is granted normally.
- Spurious `eng_done` in IDLE → no `rsp_valid`, no state change.

Source files
------------

// File: rtl/spi_cs_arbiter_if.sv
// rtl/spi_cs_arbiter_if.sv - requester and engine signal bundle for spi_cs_arbiter
interface spi_cs_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int BYTE_LEN = 8
);
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_last;
    logic [NUM_REQ*BYTE_LEN-1:0] req_data;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ-1:0]          rsp_valid;
    logic [BYTE_LEN-1:0]         rsp_data;
    logic                        hold_timeout;
    logic                        eng_start;
    logic [BYTE_LEN-1:0]         eng_tx_data;
    logic [NUM_REQ-1:0]          eng_cs_sel;
    logic                        eng_busy;
    logic                        eng_done;
    logic [BYTE_LEN-1:0]         eng_rx_data;

    modport slave (
        input  req_valid, req_last, req_data, eng_busy, eng_done, eng_rx_data,
        output req_ready, rsp_valid, rsp_data, hold_timeout,
               eng_start, eng_tx_data, eng_cs_sel
    );

    modport master (
        output req_valid, req_last, req_data, eng_busy, eng_done, eng_rx_data,
        input  req_ready, rsp_valid, rsp_data, hold_timeout,
               eng_start, eng_tx_data, eng_cs_sel
    );
endinterface

// File: rtl/spi_cs_arbiter.sv
// rtl/spi_cs_arbiter.sv - round-robin chip-select arbiter sharing one SPI byte engine
module spi_cs_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int BYTE_LEN = 8,
    parameter int CS_GAP   = 2,
    parameter int HOLD_MAX = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_cs_arbiter_if.slave  bus
);
    localparam int IDX_W    = $clog2(NUM_REQ);
    localparam int STARVE_W = $clog2(HOLD_MAX + 1);
    localparam int GAP_W    = $clog2(CS_GAP + 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_GAP} state_t;

    state_t               state, state_nx;
    logic [IDX_W-1:0]     grant;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     pick;
    logic                 last_q;
    logic [STARVE_W-1:0]  starve_cnt;
    logic [GAP_W-1:0]     gap_cnt;
    logic [NUM_REQ-1:0]   cs_sel;
    logic                 start_q;
    logic [BYTE_LEN-1:0]  tx_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [BYTE_LEN-1:0]  rsp_data_q;
    logic                 hold_q;

    logic                 any_req;
    logic                 accept;
    logic                 starve_hit;
    logic                 gap_done;
    logic [IDX_W-1:0]     grant_inc;

    // Scan offsets high to low so the lowest offset from ptr is the one that sticks.
    always_comb begin
        pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (bus.req_valid[idx]) pick = IDX_W'(idx);
        end
    end

    assign any_req    = |bus.req_valid;
    assign accept     = (state == S_SEND) && bus.req_valid[grant] && !bus.eng_busy;
    assign starve_hit = (state == S_SEND) && !bus.req_valid[grant] &&
                        (starve_cnt == STARVE_W'(HOLD_MAX - 1));
    assign gap_done   = (gap_cnt == GAP_W'(CS_GAP));
    assign grant_inc  = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        bus.req_ready = '0;
        if (accept) bus.req_ready[grant] = 1'b1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (any_req) state_nx = S_SEND;
            S_SEND: begin
                if (accept)          state_nx = S_WAIT;
                else if (starve_hit) state_nx = S_GAP;
            end
            S_WAIT: if (bus.eng_done) state_nx = last_q ? S_GAP : S_SEND;
            S_GAP:  if (gap_done) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant       <= '0;
            ptr         <= '0;
            last_q      <= 1'b0;
            starve_cnt  <= '0;
            gap_cnt     <= '0;
            cs_sel      <= '0;
            start_q     <= 1'b0;
            tx_q        <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            hold_q      <= 1'b0;
        end else begin
            start_q     <= 1'b0;
            rsp_valid_q <= '0;
            hold_q      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant      <= pick;
                        cs_sel     <= NUM_REQ'(1) << pick;
                        starve_cnt <= '0;
                    end
                end
                S_SEND: begin
                    if (accept) begin
                        start_q    <= 1'b1;
                        tx_q       <= bus.req_data[grant*BYTE_LEN +: BYTE_LEN];
                        last_q     <= bus.req_last[grant];
                        starve_cnt <= '0;
                    end else if (starve_hit) begin
                        hold_q  <= 1'b1;
                        gap_cnt <= '0;
                    end else if (!bus.req_valid[grant]) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.eng_done) begin
                        rsp_data_q         <= bus.eng_rx_data;
                        rsp_valid_q[grant] <= 1'b1;
                        gap_cnt            <= '0;
                    end
                end
                S_GAP: begin
                    // Select stays up through the response cycle, then drops for CS_GAP cycles.
                    cs_sel <= '0;
                    ptr    <= grant_inc;
                    if (!gap_done) gap_cnt <= gap_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.eng_cs_sel   = cs_sel;
    assign bus.eng_start    = start_q;
    assign bus.eng_tx_data  = tx_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.hold_timeout = hold_q;
endmodule

// File: tb/tb_spi_cs_arbiter.sv
// tb/tb_spi_cs_arbiter.sv - directed self-checking bench for spi_cs_arbiter
module tb_spi_cs_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    spi_cs_arbiter_if #(.NUM_REQ(4), .BYTE_LEN(8)) bus ();

    spi_cs_arbiter #(.NUM_REQ(4), .BYTE_LEN(8), .CS_GAP(2), .HOLD_MAX(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.req_valid   = '0;
        bus.req_last    = '0;
        bus.req_data    = '0;
        bus.eng_busy    = 1'b0;
        bus.eng_done    = 1'b0;
        bus.eng_rx_data = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Engine stand-in: waits for a start, stays busy two cycles, then returns rx.
    task automatic engine(input string tag, input logic [7:0] rx,
                          input logic [7:0] exp_tx, input logic [3:0] exp_cs);
        int n;
        n = 0;
        while (bus.eng_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_start"}, 32'(bus.eng_start), 32'd1);
        chk({tag, "_tx"}, 32'(bus.eng_tx_data), 32'(exp_tx));
        chk({tag, "_cs"}, 32'(bus.eng_cs_sel), 32'(exp_cs));
        bus.eng_busy = 1'b1;
        tick();
        chk({tag, "_start_w"}, 32'(bus.eng_start), 32'd0);
        chk({tag, "_cs_hold"}, 32'(bus.eng_cs_sel), 32'(exp_cs));
        tick();
        bus.eng_busy    = 1'b0;
        bus.eng_done    = 1'b1;
        bus.eng_rx_data = rx;
        tick();
        bus.eng_done = 1'b0;
        chk({tag, "_rspv"}, 32'(bus.rsp_valid), 32'(exp_cs));
        chk({tag, "_rspd"}, 32'(bus.rsp_data), 32'(rx));
    endtask

    initial begin
        int n;
        clear_inputs();
        do_reset();

        chk("rst_cs", 32'(bus.eng_cs_sel), 32'd0);
        chk("rst_start", 32'(bus.eng_start), 32'd0);
        chk("rst_tx", 32'(bus.eng_tx_data), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rspv", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rspd", 32'(bus.rsp_data), 32'd0);
        chk("rst_hold", 32'(bus.hold_timeout), 32'd0);

        // Spurious engine done while idle
        bus.eng_done = 1'b1;
        bus.eng_rx_data = 8'hFF;
        tick();
        bus.eng_done = 1'b0;
        chk("spur_rspv", 32'(bus.rsp_valid), 32'd0);
        chk("spur_rspd", 32'(bus.rsp_data), 32'd0);
        chk("spur_cs", 32'(bus.eng_cs_sel), 32'd0);

        // Single byte from requester 2
        bus.req_valid = 4'b0100;
        bus.req_last  = 4'b0100;
        bus.req_data  = 32'h00A5_0000;
        tick();
        chk("sb_cs_n1", 32'(bus.eng_cs_sel), 32'h4);
        chk("sb_ready_n1", 32'(bus.req_ready), 32'h4);
        chk("sb_start_n1", 32'(bus.eng_start), 32'd0);
        tick();
        chk("sb_ready_n2", 32'(bus.req_ready), 32'd0);
        engine("sb", 8'h3C, 8'hA5, 4'b0100);
        bus.req_valid = '0;
        tick();
        chk("sb_gap1", 32'(bus.eng_cs_sel), 32'd0);
        tick();
        chk("sb_gap2", 32'(bus.eng_cs_sel), 32'd0);

        // Three-byte burst from requester 1
        do_reset();
        bus.req_valid = 4'b0010;
        bus.req_last  = 4'b0000;
        bus.req_data  = 32'h0000_0100;
        engine("b1", 8'hB1, 8'h01, 4'b0010);
        bus.req_data = 32'h0000_0200;
        #1;
        chk("b1_ready_next", 32'(bus.req_ready), 32'h2);
        engine("b2", 8'hB2, 8'h02, 4'b0010);
        bus.req_data = 32'h0000_0300;
        bus.req_last = 4'b0010;
        engine("b3", 8'hB3, 8'h03, 4'b0010);
        bus.req_valid = '0;
        tick();
        chk("b3_release", 32'(bus.eng_cs_sel), 32'd0);

        // Fairness with every requester asking continuously
        do_reset();
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        bus.req_data  = 32'h1312_1110;
        for (int k = 0; k < 6; k++) begin
            engine($sformatf("fair%0d", k), 8'(8'h80 + k), 8'(8'h10 + (k % 4)), 4'(1 << (k % 4)));
        end
        bus.req_valid = '0;

        // Starvation on requester 3
        do_reset();
        bus.req_valid = 4'b1000;
        bus.req_last  = 4'b0000;
        bus.req_data  = 32'h7700_0000;
        engine("stv", 8'h99, 8'h77, 4'b1000);
        bus.req_valid = '0;
        n = 0;
        while (bus.hold_timeout !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("stv_cycles", 32'(n), 32'd64);
        chk("stv_hold", 32'(bus.hold_timeout), 32'd1);
        tick();
        chk("stv_hold_w", 32'(bus.hold_timeout), 32'd0);
        chk("stv_cs_rel", 32'(bus.eng_cs_sel), 32'd0);
        bus.req_valid = 4'b1001;
        bus.req_last  = 4'b1001;
        bus.req_data  = 32'h4300_0040;
        engine("stv_ptr", 8'h11, 8'h40, 4'b0001);
        bus.req_valid = '0;

        // Asynchronous reset in the middle of a byte
        do_reset();
        bus.req_valid = 4'b0001;
        bus.req_last  = 4'b0001;
        bus.req_data  = 32'h0000_0055;
        tick();
        tick();
        chk("ar_start", 32'(bus.eng_start), 32'd1);
        bus.eng_busy = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        chk("ar_cs", 32'(bus.eng_cs_sel), 32'd0);
        chk("ar_start0", 32'(bus.eng_start), 32'd0);
        chk("ar_tx", 32'(bus.eng_tx_data), 32'd0);
        chk("ar_ready", 32'(bus.req_ready), 32'd0);
        chk("ar_rspv", 32'(bus.rsp_valid), 32'd0);
        bus.req_valid = '0;
        tick();
        bus.eng_busy    = 1'b0;
        bus.eng_done    = 1'b1;
        bus.eng_rx_data = 8'hEE;
        tick();
        rst_n = 1'b1;
        bus.eng_done = 1'b0;
        tick();
        chk("ar_no_rsp", 32'(bus.rsp_valid), 32'd0);
        bus.req_valid = 4'b0100;
        bus.req_last  = 4'b0100;
        bus.req_data  = 32'h0066_0000;
        tick();
        chk("ar_regrant", 32'(bus.eng_cs_sel), 32'h4);
        engine("ar_txn", 8'h5A, 8'h66, 4'b0100);
        bus.req_valid = '0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
